// File: rtl/apb_sram_ctrl.sv
// APB4 completer driving a byte-writable single-port SRAM macro.
// Writes finish with no wait states, reads add one wait state, and bad addresses are answered with PSLVERR.
module apb_sram_ctrl #(
    parameter int unsigned MEM_DEPTH      = 1024,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter int unsigned APB_ADDR_WIDTH = 12
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      psel_i,
    input  logic                      penable_i,
    input  logic                      pwrite_i,
    input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
    input  logic [DATA_WIDTH-1:0]     pwdata_i,
    input  logic [3:0]                pstrb_i,
    output logic [DATA_WIDTH-1:0]     prdata_o,
    output logic                      pready_o,
    output logic                      pslverr_o,
    output logic                      sram_en_o,
    output logic                      sram_we_o,
    output logic [3:0]                sram_wbe_o,
    output logic [ADDR_WIDTH-1:0]     sram_addr_o,
    output logic [DATA_WIDTH-1:0]     sram_wdata_o,
    input  logic [DATA_WIDTH-1:0]     sram_rdata_i
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD_WAIT,
        ST_RD_DONE,
        ST_ERR
    } state_e;

    state_e                  state_q, state_d;
    logic                    sram_en_d;
    logic                    sram_we_d;
    logic [3:0]              sram_wbe_d;
    logic [ADDR_WIDTH-1:0]   sram_addr_d;
    logic [DATA_WIDTH-1:0]   sram_wdata_d;
    logic                    setup_c;
    logic                    addr_err_c;

    assign setup_c    = psel_i && !penable_i;
    assign addr_err_c = (paddr_i[1:0] != 2'b00) ||
                        (32'(paddr_i[APB_ADDR_WIDTH-1:2]) >= MEM_DEPTH);

    // Completion status is a pure decode of the state register.
    assign pready_o  = (state_q == ST_WR) || (state_q == ST_RD_DONE) || (state_q == ST_ERR);
    assign pslverr_o = (state_q == ST_ERR);
    assign prdata_o  = (state_q == ST_RD_DONE) ? sram_rdata_i : '0;

    // Next state and next SRAM command; enables default low so every command lasts one cycle.
    always_comb begin
        state_d      = state_q;
        sram_en_d    = 1'b0;
        sram_we_d    = 1'b0;
        sram_wbe_d   = 4'b0000;
        sram_addr_d  = sram_addr_o;
        sram_wdata_d = sram_wdata_o;
        case (state_q)
            ST_IDLE: begin
                if (setup_c) begin
                    if (addr_err_c) begin
                        state_d = ST_ERR;
                    end else if (pwrite_i) begin
                        state_d      = ST_WR;
                        sram_en_d    = (pstrb_i != 4'b0000);
                        sram_we_d    = (pstrb_i != 4'b0000);
                        sram_wbe_d   = pstrb_i;
                        sram_addr_d  = paddr_i[ADDR_WIDTH+1:2];
                        sram_wdata_d = pwdata_i;
                    end else begin
                        state_d     = ST_RD_WAIT;
                        sram_en_d   = 1'b1;
                        sram_addr_d = paddr_i[ADDR_WIDTH+1:2];
                    end
                end
            end
            ST_RD_WAIT: state_d = psel_i ? ST_RD_DONE : ST_IDLE;
            ST_WR,
            ST_RD_DONE,
            ST_ERR:     state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            sram_en_o    <= 1'b0;
            sram_we_o    <= 1'b0;
            sram_wbe_o   <= 4'b0000;
            sram_addr_o  <= '0;
            sram_wdata_o <= '0;
        end else begin
            state_q      <= state_d;
            sram_en_o    <= sram_en_d;
            sram_we_o    <= sram_we_d;
            sram_wbe_o   <= sram_wbe_d;
            sram_addr_o  <= sram_addr_d;
            sram_wdata_o <= sram_wdata_d;
        end
    end

endmodule

// File: tb/tb_apb_sram_ctrl.sv
// Bench for apb_sram_ctrl: directed scenarios plus random APB traffic against a word-level memory model.
// PADDR is widened to 13 bits so that byte address 0x1000 (word 1024) can be presented.
module tb_apb_sram_ctrl;

    localparam int unsigned MEM_DEPTH      = 1024;
    localparam int unsigned DATA_WIDTH     = 32;
    localparam int unsigned ADDR_WIDTH     = 10;
    localparam int unsigned APB_ADDR_WIDTH = 13;

    logic                      clk_i = 1'b0;
    logic                      rst_n_i = 1'b0;
    logic                      psel_i = 1'b0;
    logic                      penable_i = 1'b0;
    logic                      pwrite_i = 1'b0;
    logic [APB_ADDR_WIDTH-1:0] paddr_i = '0;
    logic [DATA_WIDTH-1:0]     pwdata_i = '0;
    logic [3:0]                pstrb_i = '0;
    logic [DATA_WIDTH-1:0]     prdata_o;
    logic                      pready_o;
    logic                      pslverr_o;
    logic                      sram_en_o;
    logic                      sram_we_o;
    logic [3:0]                sram_wbe_o;
    logic [ADDR_WIDTH-1:0]     sram_addr_o;
    logic [DATA_WIDTH-1:0]     sram_wdata_o;
    logic [DATA_WIDTH-1:0]     sram_rdata_i = '0;

    apb_sram_ctrl #(
        .MEM_DEPTH(MEM_DEPTH), .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH), .APB_ADDR_WIDTH(APB_ADDR_WIDTH)
    ) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .psel_i(psel_i), .penable_i(penable_i), .pwrite_i(pwrite_i),
        .paddr_i(paddr_i), .pwdata_i(pwdata_i), .pstrb_i(pstrb_i),
        .prdata_o(prdata_o), .pready_o(pready_o), .pslverr_o(pslverr_o),
        .sram_en_o(sram_en_o), .sram_we_o(sram_we_o), .sram_wbe_o(sram_wbe_o),
        .sram_addr_o(sram_addr_o), .sram_wdata_o(sram_wdata_o), .sram_rdata_i(sram_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // SRAM macro stand-in: byte-masked write, one-cycle registered read.
    logic [31:0] sram_mem [MEM_DEPTH];
    always @(posedge clk_i) begin
        if (sram_en_o) begin
            if (sram_we_o) begin
                for (int i = 0; i < 4; i++)
                    if (sram_wbe_o[i]) sram_mem[sram_addr_o][8*i +: 8] <= sram_wdata_o[8*i +: 8];
            end else begin
                sram_rdata_i <= sram_mem[sram_addr_o];
            end
        end
    end

    // Reference contents as seen through APB.
    logic [31:0] ref_mem [MEM_DEPTH];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // What the access cycles showed on the SRAM port.
    int          en_cnt;
    logic [31:0] en_addr;
    logic        en_we;
    logic [3:0]  en_wbe;
    logic [31:0] en_wdata;

    task automatic sample_sram();
        if (sram_en_o) begin
            en_cnt++;
            en_addr  = 32'(sram_addr_o);
            en_we    = sram_we_o;
            en_wbe   = sram_wbe_o;
            en_wdata = sram_wdata_o;
        end
    endtask

    // One APB transfer; starts on the next falling edge, leaves psel high for back-to-back use.
    task automatic apb_xfer(input logic wr, input logic [APB_ADDR_WIDTH-1:0] addr,
                            input logic [31:0] wdata, input logic [3:0] strb,
                            output logic [31:0] rdata, output logic err, output int cyc);
        int guard;
        en_cnt = 0; en_addr = 0; en_we = 0; en_wbe = 0; en_wdata = 0;
        @(negedge clk_i);
        psel_i = 1'b1; penable_i = 1'b0; pwrite_i = wr;
        paddr_i = addr; pwdata_i = wdata; pstrb_i = strb;
        @(negedge clk_i);
        penable_i = 1'b1;
        cyc = 2;
        guard = 0;
        sample_sram();
        while (!pready_o) begin
            check("pslverr_without_pready", 32'(pslverr_o), 32'd0);
            guard++;
            if (guard > 8) begin
                check("pready_timeout", 32'(pready_o), 32'd1);
                break;
            end
            @(negedge clk_i);
            cyc++;
            sample_sram();
        end
        rdata = prdata_o;
        err   = pslverr_o;
    endtask

    task automatic idle(input int n);
        @(negedge clk_i);
        psel_i = 1'b0; penable_i = 1'b0;
        for (int i = 1; i < n; i++) @(negedge clk_i);
    endtask

    // Transfer plus expectations computed from the address map and byte-lane rules.
    task automatic do_xfer(input string tag, input logic wr, input logic [APB_ADDR_WIDTH-1:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb, output logic [31:0] rdata);
        logic        err;
        int          cyc;
        int unsigned word;
        logic        exp_err;
        int          exp_en;
        word    = 32'(addr) / 4;
        exp_err = (addr % 4 != 0) || (word >= MEM_DEPTH);
        apb_xfer(wr, addr, wdata, strb, rdata, err, cyc);
        exp_en  = exp_err ? 0 : (wr ? ((strb != 0) ? 1 : 0) : 1);
        check({tag, "_pslverr"}, 32'(err), 32'(exp_err));
        check({tag, "_cycles"}, 32'(cyc), (exp_err || wr) ? 32'd2 : 32'd3);
        check({tag, "_en_pulses"}, 32'(en_cnt), 32'(exp_en));
        if (exp_en != 0) begin
            check({tag, "_sram_addr"}, en_addr, word);
            check({tag, "_sram_we"}, 32'(en_we), 32'(wr));
            check({tag, "_sram_wbe"}, 32'(en_wbe), wr ? 32'(strb) : 32'd0);
            if (wr) check({tag, "_sram_wdata"}, en_wdata, wdata);
        end
        check({tag, "_prdata"}, rdata, (!wr && !exp_err) ? ref_mem[word] : 32'd0);
        if (wr && !exp_err)
            for (int i = 0; i < 4; i++)
                if (strb[i]) ref_mem[word][8*i +: 8] = wdata[8*i +: 8];
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] r;
        logic [APB_ADDR_WIDTH-1:0] a;
        logic [3:0] s;

        for (int i = 0; i < int'(MEM_DEPTH); i++) begin
            sram_mem[i] = '0;
            ref_mem[i]  = '0;
        end

        // Reset values
        #12;
        check("rst_pready", 32'(pready_o), 0);
        check("rst_pslverr", 32'(pslverr_o), 0);
        check("rst_prdata", prdata_o, 0);
        check("rst_sram_en", 32'(sram_en_o), 0);
        check("rst_sram_we", 32'(sram_we_o), 0);
        check("rst_sram_wbe", 32'(sram_wbe_o), 0);
        check("rst_sram_addr", 32'(sram_addr_o), 0);
        check("rst_sram_wdata", sram_wdata_o, 0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        idle(2);

        // Full write then read
        do_xfer("wr_010", 1'b1, 13'h010, 32'hDEADBEEF, 4'hF, rd);
        do_xfer("rd_010", 1'b0, 13'h010, 32'h0, 4'h0, rd);
        check("rd_010_const", rd, 32'hDEADBEEF);
        idle(1);

        // Byte strobes
        do_xfer("wr_020_pre", 1'b1, 13'h020, 32'h11223344, 4'hF, rd);
        do_xfer("wr_020_strb", 1'b1, 13'h020, 32'hAABBCCDD, 4'h5, rd);
        do_xfer("rd_020", 1'b0, 13'h020, 32'h0, 4'h0, rd);
        check("rd_020_const", rd, 32'h11BB33DD);
        idle(1);

        // Error responses
        do_xfer("rd_oor", 1'b0, 13'h1000, 32'h0, 4'h0, rd);
        do_xfer("wr_misal", 1'b1, 13'h006, 32'hFFFFFFFF, 4'hF, rd);
        do_xfer("rd_004", 1'b0, 13'h004, 32'h0, 4'h0, rd);
        idle(2);

        // Back-to-back without idle cycles
        do_xfer("b2b_wr0", 1'b1, 13'h000, 32'hCAFE0000, 4'hF, rd);
        do_xfer("b2b_rd0", 1'b0, 13'h000, 32'h0, 4'h0, rd);
        do_xfer("b2b_wr4", 1'b1, 13'h004, 32'h0000F00D, 4'hF, rd);
        do_xfer("b2b_rd4", 1'b0, 13'h004, 32'h0, 4'h0, rd);
        check("b2b_rd4_const", rd, 32'h0000F00D);

        // Write with no strobes touches nothing
        do_xfer("wr_nostrb", 1'b1, 13'h010, 32'h12345678, 4'h0, rd);
        idle(1);

        // Reset during RD_WAIT
        @(negedge clk_i);
        psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b0; paddr_i = 13'h010;
        @(negedge clk_i);
        penable_i = 1'b1;
        check("rdwait_pready", 32'(pready_o), 0);
        check("rdwait_en", 32'(sram_en_o), 1);
        rst_n_i = 1'b0;
        #1;
        check("midrst_en", 32'(sram_en_o), 0);
        check("midrst_we", 32'(sram_we_o), 0);
        check("midrst_addr", 32'(sram_addr_o), 0);
        check("midrst_pready", 32'(pready_o), 0);
        check("midrst_prdata", prdata_o, 0);
        idle(2);
        check("midrst_en_hold", 32'(sram_en_o), 0);
        rst_n_i = 1'b1;
        do_xfer("rd_010_after_rst", 1'b0, 13'h010, 32'h0, 4'h0, rd);
        check("rd_010_after_rst_const", rd, 32'hDEADBEEF);

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 9);
            a = 13'($urandom);
            if (r == 0) begin
                if (a[1:0] == 2'b00) a[0] = 1'b1;
            end else if (r == 1) begin
                a[12] = 1'b1;
                a[1:0] = 2'b00;
            end else begin
                a = 13'($urandom_range(0, 31) * 4);
            end
            r = $urandom;
            s = 4'(r);
            if (r[8]) s = 4'hF;
            do_xfer("rnd", r[4], a, $urandom, s, rd);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
